clock_factor_ctrl: RTL and testbench



---
 rtl/clock_factor_ctrl.sv | 149 ++++++++++++++
 tb/tb_clock_factor_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_factor_ctrl.sv
// Division-factor controller: debounces up/down/mode buttons, owns the 5-bit
// factor register and pulses the divider reset around every factor change.
module clock_factor_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DIV_RST_CYCLES  = 4,
  parameter int SWEEP_PERIOD    = 100000000,
  parameter int FACTOR_MIN      = 0,
  parameter int FACTOR_MAX      = 31,
  parameter int FACTOR_RESET    = 10
) (
  input  logic       clock_factor_ctrl_clk,
  input  logic       clock_factor_ctrl_rst,
  input  logic       clock_factor_ctrl_btn_up,
  input  logic       clock_factor_ctrl_btn_down,
  input  logic       clock_factor_ctrl_btn_mode,
  output logic [4:0] clock_factor_ctrl_factor,
  output logic       clock_factor_ctrl_div_rst,
  output logic       clock_factor_ctrl_mode,
  output logic       clock_factor_ctrl_busy
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int SW = $clog2(SWEEP_PERIOD);
  localparam int HW = $clog2(DIV_RST_CYCLES + 1);

  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SWEEP_LAST = SW'(SWEEP_PERIOD - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(DIV_RST_CYCLES - 1);
  localparam logic [4:0]    F_MIN      = 5'(FACTOR_MIN);
  localparam logic [4:0]    F_MAX      = 5'(FACTOR_MAX);
  localparam logic [4:0]    F_RST      = 5'(FACTOR_RESET);

  typedef enum logic {IDLE, HOLD} state_t;

  // Button index: 0 = up, 1 = down, 2 = mode.
  logic [2:0]    raw;
  logic [2:0]    sync1, sync2, deb, deb_q, press;
  logic [DW-1:0] db_cnt [3];

  assign raw = {clock_factor_ctrl_btn_mode, clock_factor_ctrl_btn_down,
                clock_factor_ctrl_btn_up};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clock_factor_ctrl_clk) begin
    if (clock_factor_ctrl_rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      press <= deb & ~deb_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  state_t        state, state_n;
  logic [4:0]    factor, factor_n, nf, up_nf, dn_nf, wrap_nf;
  logic          div_rst, div_rst_n, mode, mode_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic [SW-1:0] sweep_cnt, sweep_cnt_n;

  // Bounds are compared before stepping so the 5-bit factor never overflows.
  assign up_nf   = (factor == F_MAX) ? factor : factor + 5'd1;
  assign dn_nf   = (factor == F_MIN) ? factor : factor - 5'd1;
  assign wrap_nf = (factor == F_MAX) ? F_MIN  : factor + 5'd1;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    factor_n    = factor;
    div_rst_n   = div_rst;
    mode_n      = mode;
    hold_cnt_n  = hold_cnt;
    sweep_cnt_n = sweep_cnt;
    nf          = press[0] ? up_nf : dn_nf;
    case (state)
      IDLE: begin
        if (press[2]) begin
          mode_n      = ~mode;
          sweep_cnt_n = '0;
        end else if (!mode) begin
          if ((press[0] ^ press[1]) && (nf != factor)) begin
            factor_n   = nf;
            div_rst_n  = 1'b1;
            hold_cnt_n = '0;
            state_n    = HOLD;
          end
        end else if (sweep_cnt == SWEEP_LAST) begin
          sweep_cnt_n = '0;
          factor_n    = wrap_nf;
          div_rst_n   = 1'b1;
          hold_cnt_n  = '0;
          state_n     = HOLD;
        end else begin
          sweep_cnt_n = sweep_cnt + SW'(1);
        end
      end
      HOLD: begin
        // Presses arriving here are simply not looked at, hence dropped.
        if (hold_cnt == HOLD_LAST) begin
          state_n   = IDLE;
          div_rst_n = 1'b0;
        end else begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock_factor_ctrl_clk) begin
    if (clock_factor_ctrl_rst) begin
      state     <= IDLE;
      factor    <= F_RST;
      div_rst   <= 1'b0;
      mode      <= 1'b0;
      hold_cnt  <= '0;
      sweep_cnt <= '0;
    end else begin
      state     <= state_n;
      factor    <= factor_n;
      div_rst   <= div_rst_n;
      mode      <= mode_n;
      hold_cnt  <= hold_cnt_n;
      sweep_cnt <= sweep_cnt_n;
    end
  end

  assign clock_factor_ctrl_factor  = factor;
  assign clock_factor_ctrl_div_rst = div_rst;
  assign clock_factor_ctrl_mode    = mode;
  assign clock_factor_ctrl_busy    = (state == HOLD);

endmodule

// File: tb/tb_clock_factor_ctrl.sv
// Bench for clock_factor_ctrl: directed scenarios plus random button traffic,
// every cycle compared against a behavioural model of the controller.
module tb_clock_factor_ctrl;

  localparam int DB   = 4;
  localparam int HOLD = 2;
  localparam int SWP  = 8;
  localparam int FMIN = 0;
  localparam int FMAX = 31;
  localparam int FRST = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_mode = 1'b0;
  logic [4:0] factor;
  logic       div_rst, mode, busy;

  int vectors = 0;
  int miscompares = 0;
  int div_cycles = 0;

  clock_factor_ctrl #(
    .DEBOUNCE_CYCLES(DB), .DIV_RST_CYCLES(HOLD), .SWEEP_PERIOD(SWP),
    .FACTOR_MIN(FMIN), .FACTOR_MAX(FMAX), .FACTOR_RESET(FRST)
  ) dut (
    .clock_factor_ctrl_clk     (clk),
    .clock_factor_ctrl_rst     (rst),
    .clock_factor_ctrl_btn_up  (btn_up),
    .clock_factor_ctrl_btn_down(btn_down),
    .clock_factor_ctrl_btn_mode(btn_mode),
    .clock_factor_ctrl_factor  (factor),
    .clock_factor_ctrl_div_rst (div_rst),
    .clock_factor_ctrl_mode    (mode),
    .clock_factor_ctrl_busy    (busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: per-button pipeline state, then factor / hold countdown.
  int m_q1[3], m_q2[3], m_d[3], m_dp[3], m_p[3], m_run[3];
  int m_factor, m_mode, m_hold_left, m_sweep;

  task automatic model_tick();
    int raw [3];
    int target;
    raw[0] = int'(btn_up); raw[1] = int'(btn_down); raw[2] = int'(btn_mode);
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_q1[i] = 0; m_q2[i] = 0; m_d[i] = 0; m_dp[i] = 0; m_p[i] = 0; m_run[i] = 0;
      end
      m_factor = FRST; m_mode = 0; m_hold_left = 0; m_sweep = 0;
      return;
    end
    if (m_hold_left > 0) begin
      m_hold_left--;
    end else if (m_p[2] != 0) begin
      m_mode  = 1 - m_mode;
      m_sweep = 0;
    end else if (m_mode == 0) begin
      if (m_p[0] != m_p[1]) begin
        target = (m_p[0] != 0) ? m_factor + 1 : m_factor - 1;
        if (target > FMAX) target = FMAX;
        if (target < FMIN) target = FMIN;
        if (target != m_factor) begin
          m_factor    = target;
          m_hold_left = HOLD;
        end
      end
    end else if (m_sweep == SWP - 1) begin
      m_sweep     = 0;
      m_factor    = (m_factor == FMAX) ? FMIN : m_factor + 1;
      m_hold_left = HOLD;
    end else begin
      m_sweep++;
    end
    for (int i = 0; i < 3; i++) begin
      m_p[i]  = (m_d[i] != 0 && m_dp[i] == 0) ? 1 : 0;
      m_dp[i] = m_d[i];
      if (m_q2[i] != m_d[i]) begin
        if (m_run[i] == DB - 1) begin
          m_d[i]   = m_q2[i];
          m_run[i] = 0;
        end else begin
          m_run[i]++;
        end
      end else begin
        m_run[i] = 0;
      end
      m_q2[i] = m_q1[i];
      m_q1[i] = raw[i];
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("factor",  32'(factor),  32'(m_factor));
    check("div_rst", 32'(div_rst), (m_hold_left > 0) ? 32'd1 : 32'd0);
    check("busy",    32'(busy),    (m_hold_left > 0) ? 32'd1 : 32'd0);
    check("mode",    32'(mode),    32'(m_mode));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_tick();
    if (div_rst) div_cycles++;
    check_all();
  endtask

  task automatic press(input int idx);
    if (idx == 0) btn_up = 1'b1; else if (idx == 1) btn_down = 1'b1; else btn_mode = 1'b1;
    repeat (10) step();
    btn_up = 1'b0; btn_down = 1'b0; btn_mode = 1'b0;
    repeat (10) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    int first_chg, n_chg, n_div, d0, prev, saw_wrap, seen;

    // Reset state
    do_reset();
    check("rst_factor", 32'(factor), 32'd10);
    check("rst_div", 32'(div_rst), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mode", 32'(mode), 32'd0);

    // Held up button: one step, fixed latency, two-cycle divider reset
    btn_up = 1'b1; first_chg = -1; n_chg = 0; n_div = 0; prev = int'(factor);
    for (int i = 0; i < 20; i++) begin
      step();
      if (int'(factor) != prev) begin
        n_chg++;
        if (first_chg < 0) first_chg = i;
      end
      prev = int'(factor);
      if (div_rst) n_div++;
    end
    check("t1_latency", 32'(first_chg), 32'd7);
    check("t1_steps", 32'(n_chg), 32'd1);
    check("t1_div_len", 32'(n_div), 32'd2);
    check("t1_factor", 32'(factor), 32'd11);
    btn_up = 1'b0;
    repeat (12) step();

    // Bouncing button never stable long enough, then stable: single step
    for (int i = 0; i < 8; i++) begin
      btn_up = ((i % 4) < 2);
      step();
      check("t2_no_change", 32'(factor), 32'd11);
    end
    btn_up = 1'b1;
    repeat (12) step();
    check("t2_factor", 32'(factor), 32'd12);
    btn_up = 1'b0;
    repeat (12) step();

    // Saturation at both bounds
    repeat (19) press(0);
    check("t3_at_max", 32'(factor), 32'd31);
    d0 = div_cycles;
    press(0);
    check("t3_max_hold", 32'(factor), 32'd31);
    check("t3_max_nodiv", 32'(div_cycles - d0), 32'd0);
    repeat (31) press(1);
    check("t3_at_min", 32'(factor), 32'd0);
    d0 = div_cycles;
    press(1);
    check("t3_min_hold", 32'(factor), 32'd0);
    check("t3_min_nodiv", 32'(div_cycles - d0), 32'd0);

    // Sweep mode with wrap; up/down traffic must not matter
    do_reset();
    press(2);
    check("t4_mode", 32'(mode), 32'd1);
    saw_wrap = 0; prev = int'(factor);
    for (int i = 0; i < 240; i++) begin
      if (i % 6 == 0) begin
        btn_up   = 1'($urandom_range(0, 1));
        btn_down = 1'($urandom_range(0, 1));
      end
      step();
      if (prev == 31 && factor == 5'd0) saw_wrap = 1;
      prev = int'(factor);
    end
    btn_up = 1'b0; btn_down = 1'b0;
    check("t4_wrapped", 32'(saw_wrap), 32'd1);
    check("t4_mode_kept", 32'(mode), 32'd1);

    // Press landing in HOLD is dropped; simultaneous up+down ignored
    do_reset();
    btn_down = 1'b1;
    step();
    btn_up = 1'b1;
    repeat (12) step();
    btn_up = 1'b0; btn_down = 1'b0;
    repeat (12) step();
    check("t5_dropped", 32'(factor), 32'd9);
    d0 = div_cycles;
    btn_up = 1'b1; btn_down = 1'b1;
    repeat (12) step();
    btn_up = 1'b0; btn_down = 1'b0;
    repeat (12) step();
    check("t5_both_factor", 32'(factor), 32'd9);
    check("t5_both_nodiv", 32'(div_cycles - d0), 32'd0);

    // Reset on first HOLD cycle aborts the hold
    btn_up = 1'b1; seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      step();
      if (div_rst) seen = 1;
    end
    check("t6_hold_seen", 32'(seen), 32'd1);
    btn_up = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_factor", 32'(factor), 32'd10);
    check("t6_div", 32'(div_rst), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_mode", 32'(mode), 32'd0);
    repeat (5) step();

    // Random button traffic with occasional resets
    for (int seg = 0; seg < 80; seg++) begin
      btn_up   = 1'($urandom_range(0, 1));
      btn_down = 1'($urandom_range(0, 1));
      btn_mode = ($urandom_range(0, 5) == 0);
      rst      = ($urandom_range(0, 39) == 0);
      repeat ($urandom_range(1, 12)) step();
      rst = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
